// File: rtl/console_pkg.sv
// Shared types and constants for the text console write-port sequencer.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_TAB = 8'h09;

  typedef logic [11:0] vram_addr_t;

  // Length of a full-address-space clear (every VRAM cell, including off-screen ones).
  localparam logic [12:0] CLEAR_LEN = 13'd4096;

endpackage

// File: rtl/console_fill.sv
// Address-stream generator for VRAM fills: issues one write per cycle from
// base for len cells. Reset arms a full clear from address 0 so the screen is
// wiped right after reset without the controller having to issue a start.
module console_fill
  import console_pkg::*;
(
  input  logic        clk_pix,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] base,
  input  logic [12:0] len,
  output logic        we,
  output logic [11:0] addr,
  output logic        done
);

  logic        run_q, run_d;
  vram_addr_t  nxt_q, nxt_d;
  logic [12:0] left_q, left_d;

  // Next-state for the fill counter: load on start, otherwise step while running.
  always_comb begin
    run_d  = run_q;
    nxt_d  = nxt_q;
    left_d = left_q;
    if (start) begin
      run_d  = 1'b1;
      nxt_d  = base;
      left_d = len;
    end else if (run_q) begin
      nxt_d  = nxt_q + 12'd1;
      left_d = left_q - 13'd1;
      if (left_q == 13'd1) run_d = 1'b0;
    end
  end

  // Fill counter registers.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      run_q  <= 1'b1;
      nxt_q  <= '0;
      left_q <= CLEAR_LEN;
    end else begin
      run_q  <= run_d;
      nxt_q  <= nxt_d;
      left_q <= left_d;
    end
  end

  assign we   = run_q;
  assign addr = nxt_q;
  assign done = ~run_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Text-mode VRAM write sequencer: consumes a byte stream, tracks the cursor,
// writes glyphs, clears the screen and scrolls by moving scroll_row.
// Optional feature: define CONSOLE_TAB_EN to treat 0x09 as a tab-stop move.
//
//   state | meaning
//   IDLE  | ready for a byte
//   WRITE | one cycle after accept; glyph write (if any) on the port
//   CLEAR | filling all 4096 cells with FILL_CHAR
//   BLANK | filling the COLS cells of a newly exposed row
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk_pix,
  input  logic        rst,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [7:0]  ch_data,
  output logic        vram_we,
  output logic [11:0] vram_waddr,
  output logic [7:0]  vram_din,
  output logic [4:0]  scroll_row,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [12:0] ROW_LEN  = 13'(COLS);

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  scroll_q, scroll_d;
  logic        pend_q, pend_d;
  logic [4:0]  pend_row_q, pend_row_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  vram_addr_t  waddr_q, waddr_d;
  logic [7:0]  din_q, din_d;

  logic        fill_start;
  vram_addr_t  fill_base;
  logic [12:0] fill_len;
  logic        fill_we;
  vram_addr_t  fill_addr;
  logic        fill_done;

  logic [4:0]  phys;
  logic        nl, nl_defer, nl_scroll_en;
  logic [4:0]  nl_row, nl_scroll, nl_blank;
`ifdef CONSOLE_TAB_EN
  logic [7:0]  tab_col;
`endif

  console_fill u_fill (
    .clk_pix (clk_pix),
    .rst     (rst),
    .start   (fill_start),
    .base    (fill_base),
    .len     (fill_len),
    .we      (fill_we),
    .addr    (fill_addr),
    .done    (fill_done)
  );

  // Byte decode, cursor/scroll update and write-port selection.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scroll_d   = scroll_q;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    din_d      = din_q;
    fill_start = 1'b0;
    fill_base  = {pend_row_q, 7'd0};
    fill_len   = ROW_LEN;
    nl         = 1'b0;
    nl_defer   = 1'b0;

    phys         = row_q + scroll_q;
    nl_scroll_en = (row_q == LAST_ROW);
    nl_row       = nl_scroll_en ? row_q : row_q + 5'd1;
    nl_scroll    = nl_scroll_en ? scroll_q + 5'd1 : scroll_q;
    nl_blank     = nl_scroll + LAST_ROW;
`ifdef CONSOLE_TAB_EN
    tab_col      = {1'b0, col_q[6:3], 3'b000} + 8'd8;
`endif

    case (state_q)
      IDLE: begin
        if (ch_valid && ready_q) begin
          ready_d = 1'b0;
          state_d = WRITE;
          if (ch_data == CH_CR) begin
            col_d = '0;
          end else if (ch_data == CH_BS) begin
            if (col_q != '0) col_d = col_q - 7'd1;
          end else if (ch_data == CH_FF) begin
            state_d    = CLEAR;
            busy_d     = 1'b1;
            fill_start = 1'b1;
            fill_base  = '0;
            fill_len   = CLEAR_LEN;
          end else if (ch_data == CH_LF) begin
            nl = 1'b1;
`ifdef CONSOLE_TAB_EN
          end else if (ch_data == CH_TAB) begin
            if (tab_col >= 8'(COLS)) begin
              col_d = '0;
              nl    = 1'b1;
            end else begin
              col_d = tab_col[6:0];
            end
`endif
          end else begin
            we_d    = 1'b1;
            waddr_d = {phys, col_q};
            din_d   = ch_data;
            if (col_q == LAST_COL) begin
              col_d    = '0;
              nl       = 1'b1;
              // The glyph write must land before the blank starts, so the
              // blank is queued and launched from WRITE.
              nl_defer = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
        end
      end
      WRITE: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          state_d    = BLANK;
          busy_d     = 1'b1;
          fill_start = 1'b1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      CLEAR, BLANK: begin
        if (fill_we) begin
          we_d    = 1'b1;
          waddr_d = fill_addr;
          din_d   = FILL_CHAR;
        end else if (fill_done) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          if (state_q == CLEAR) begin
            row_d    = '0;
            col_d    = '0;
            scroll_d = '0;
          end
        end
      end
      default: ;
    endcase

    if (nl) begin
      row_d    = nl_row;
      scroll_d = nl_scroll;
      if (nl_scroll_en) begin
        if (nl_defer) begin
          pend_d     = 1'b1;
          pend_row_d = nl_blank;
        end else begin
          state_d    = BLANK;
          busy_d     = 1'b1;
          fill_start = 1'b1;
          fill_base  = {nl_blank, 7'd0};
          fill_len   = ROW_LEN;
        end
      end
    end
  end

  // FSM and registered outputs; reset restarts the full clear.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q    <= CLEAR;
      row_q      <= '0;
      col_q      <= '0;
      scroll_q   <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      scroll_q   <= scroll_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
    end
  end

  assign ch_ready   = ready_q;
  assign busy       = busy_q;
  assign vram_we    = we_q;
  assign vram_waddr = waddr_q;
  assign vram_din   = din_q;
  assign scroll_row = scroll_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl with a screen-level reference model.
module tb_text_console_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk_pix = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic        vram_we;
  logic [11:0] vram_waddr;
  logic [7:0]  vram_din;
  logic [4:0]  scroll_row;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  always #5 clk_pix = ~clk_pix;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(8'h20)) dut (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .ch_data    (ch_data),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_din   (vram_din),
    .scroll_row (scroll_row),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  int tests = 0;
  int failed = 0;

  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  logic [19:0] wq[$];
  int          wcq[$];
  logic [7:0]  shadow [4096];

  // Write/accept monitor: samples what was on the port during the cycle just ended.
  always @(posedge clk_pix) begin
    if (vram_we) begin
      wq.push_back({vram_waddr, vram_din});
      wcq.push_back(cyc);
      shadow[vram_waddr] = vram_din;
    end
    if (ch_valid && ch_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    cyc++;
  end

  // Reference model: logical screen state and expected VRAM image.
  logic [7:0] exp_mem [4096];
  int m_row, m_col, m_scroll;

  function automatic void m_clear();
    for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h20;
    m_row = 0; m_col = 0; m_scroll = 0;
  endfunction

  function automatic logic [11:0] m_addr();
    return 12'((((m_row + m_scroll) % 32) * 128) + m_col);
  endfunction

  function automatic void m_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      int r;
      m_scroll = (m_scroll + 1) % 32;
      r = (m_scroll + ROWS - 1) % 32;
      for (int c = 0; c < COLS; c++) exp_mem[r * 128 + c] = 8'h20;
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (b == 8'h0D) m_col = 0;
    else if (b == 8'h08) begin if (m_col > 0) m_col--; end
    else if (b == 8'h0C) m_clear();
    else if (b == 8'h0A) m_newline();
`ifdef CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      m_col = (m_col / 8 + 1) * 8;
      if (m_col >= COLS) begin m_col = 0; m_newline(); end
    end
`endif
    else begin
      exp_mem[m_addr()] = b;
      m_col++;
      if (m_col == COLS) begin m_col = 0; m_newline(); end
    end
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_pix);
    while (!(ch_ready && !busy) && n < 9000) begin
      @(negedge clk_pix);
      n++;
    end
    if (!(ch_ready && !busy)) begin
      tests++; failed++;
      $display("FAIL %s_idle_timeout: ch_ready=%0b busy=%0b, required ch_ready=1 busy=0", tag, ch_ready, busy);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!ch_ready && n < 9000) begin
      @(negedge clk_pix);
      n++;
    end
    if (!ch_ready) begin
      tests++; failed++;
      $display("FAIL send_ready_timeout: ch_ready=%0b, required 1", ch_ready);
    end else begin
      ch_valid = 1'b1;
      ch_data  = b;
      @(negedge clk_pix);
      ch_valid = 1'b0;
      m_byte(b);
    end
  endtask

  task automatic test_reset();
    int err = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk_pix);
    tests++;
    if (busy !== 1'b1 || ch_ready !== 1'b0 || vram_we !== 1'b0 || vram_waddr !== 12'h000 ||
        vram_din !== 8'h00 || scroll_row !== 5'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      failed++;
      $display("FAIL reset_values: busy=%0b ready=%0b we=%0b addr=%h din=%h scroll=%0d cur=(%0d,%0d), required 1 0 0 000 00 0 (0,0)",
               busy, ch_ready, vram_we, vram_waddr, vram_din, scroll_row, cursor_row, cursor_col);
    end
    wq.delete(); wcq.delete();
    rst = 1'b0;
    wait_idle("reset");
    m_clear();
    tests++;
    if (wq.size() != 4096) begin
      failed++;
      $display("FAIL reset_clear_count: got %0d writes, required 4096", wq.size());
    end
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== {12'(i), 8'h20}) err++;
    tests++;
    if (err != 0) begin
      failed++;
      $display("FAIL reset_clear_seq: %0d bad writes, required 0", err);
    end
    tests++;
    if (ch_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0 || scroll_row !== 5'd0) begin
      failed++;
      $display("FAIL reset_after_clear: ready=%0b cur=(%0d,%0d) scroll=%0d, required 1 (0,0) 0",
               ch_ready, cursor_row, cursor_col, scroll_row);
    end
  endtask

  task automatic test_single_char();
    wq.delete(); wcq.delete();
    send_byte(8'h41);
    tests++;
    if (ch_ready !== 1'b0) begin
      failed++;
      $display("FAIL single_ready_low: ch_ready=%0b at N+1, required 0", ch_ready);
    end
    @(negedge clk_pix);
    tests++;
    if (ch_ready !== 1'b1) begin
      failed++;
      $display("FAIL single_ready_high: ch_ready=%0b at N+2, required 1", ch_ready);
    end
    tests++;
    if (wq.size() != 1 || wq[0] !== {12'h000, 8'h41} || wcq[0] != acc_cyc + 1) begin
      failed++;
      $display("FAIL single_write: n=%0d first=%h cyc=%0d, required n=1 first=00041 cyc=%0d",
               wq.size(), wq.size() > 0 ? wq[0] : 20'h0, wcq.size() > 0 ? wcq[0] : -1, acc_cyc + 1);
    end
    tests++;
    if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
      failed++;
      $display("FAIL single_cursor: cur=(%0d,%0d), required (0,1)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_line_wrap();
    send_byte(8'h0D);
    wait_idle("wrap_cr");
    wq.delete();
    for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(33, 126)));
    wait_idle("wrap");
    tests++;
    if (wq.size() != COLS || wq[COLS-1][19:8] !== 12'h04F) begin
      failed++;
      $display("FAIL wrap_last_write: n=%0d last_addr=%h, required n=80 last_addr=04f",
               wq.size(), wq.size() > 0 ? wq[wq.size()-1][19:8] : 12'h0);
    end
    tests++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
      failed++;
      $display("FAIL wrap_cursor: cur=(%0d,%0d), required (1,0)", cursor_row, cursor_col);
    end
    wq.delete();
    send_byte(8'h78);
    wait_idle("wrap_next");
    tests++;
    if (wq.size() != 1 || wq[0] !== {12'h080, 8'h78}) begin
      failed++;
      $display("FAIL wrap_next_write: n=%0d first=%h, required n=1 first=08078",
               wq.size(), wq.size() > 0 ? wq[0] : 20'h0);
    end
  endtask

  task automatic test_scroll();
    int err = 0;
    send_byte(8'h0D);
    while (m_row < ROWS - 1) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(33, 126)));
    wait_idle("scroll_setup");
    tests++;
    if (cursor_row !== 5'd29 || cursor_col !== 7'd5 || scroll_row !== 5'd0) begin
      failed++;
      $display("FAIL scroll_setup: cur=(%0d,%0d) scroll=%0d, required (29,5) 0", cursor_row, cursor_col, scroll_row);
    end
    wq.delete();
    send_byte(8'h0A);
    wait_idle("scroll_lf");
    tests++;
    if (scroll_row !== 5'd1 || cursor_row !== 5'd29 || cursor_col !== 7'd5) begin
      failed++;
      $display("FAIL scroll_state: cur=(%0d,%0d) scroll=%0d, required (29,5) 1", cursor_row, cursor_col, scroll_row);
    end
    for (int i = 0; i < wq.size(); i++) begin
      logic [11:0] ea;
      ea = 12'hF00 + 12'(i);
      if (wq[i] !== {ea, 8'h20}) err++;
    end
    tests++;
    if (wq.size() != COLS || err != 0) begin
      failed++;
      $display("FAIL scroll_blank: n=%0d bad=%0d, required n=80 bad=0", wq.size(), err);
    end
    wq.delete();
    send_byte(8'h42);
    wait_idle("scroll_b");
    tests++;
    if (wq.size() != 1 || wq[0] !== {12'hF05, 8'h42}) begin
      failed++;
      $display("FAIL scroll_next_write: n=%0d first=%h, required n=1 first=f0542",
               wq.size(), wq.size() > 0 ? wq[0] : 20'h0);
    end
  endtask

  task automatic test_bs_ff();
    send_byte(8'h0D);
    wait_idle("bs_cr");
    wq.delete();
    send_byte(8'h08);
    wait_idle("bs0");
    tests++;
    if (wq.size() != 0 || cursor_col !== 7'd0) begin
      failed++;
      $display("FAIL bs_at_col0: writes=%0d col=%0d, required 0 0", wq.size(), cursor_col);
    end
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h08);
    wait_idle("bs2");
    tests++;
    if (wq.size() != 2 || cursor_col !== 7'd1) begin
      failed++;
      $display("FAIL bs_at_col2: writes=%0d col=%0d, required 2 1", wq.size(), cursor_col);
    end
    wq.delete();
    send_byte(8'h0C);
    wait_idle("ff");
    tests++;
    if (wq.size() != 4096 || wq[0] !== {12'h000, 8'h20} || wq[4095] !== {12'hFFF, 8'h20}) begin
      failed++;
      $display("FAIL ff_clear: n=%0d first=%h last=%h, required 4096 00020 fff20",
               wq.size(), wq.size() > 0 ? wq[0] : 20'h0, wq.size() > 4095 ? wq[4095] : 20'h0);
    end
    tests++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || scroll_row !== 5'd0) begin
      failed++;
      $display("FAIL ff_state: cur=(%0d,%0d) scroll=%0d, required (0,0) 0", cursor_row, cursor_col, scroll_row);
    end
  endtask

  task automatic test_tab();
    logic [11:0] ea;
    int er;
    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(33, 126)));
    wait_idle("tab_setup");
    ea = m_addr();
    wq.delete();
    send_byte(8'h09);
    wait_idle("tab3");
`ifdef CONSOLE_TAB_EN
    tests++;
    if (wq.size() != 0 || cursor_col !== 7'd8) begin
      failed++;
      $display("FAIL tab_col3: writes=%0d col=%0d, required 0 8", wq.size(), cursor_col);
    end
    send_byte(8'h0D);
    for (int i = 0; i < 78; i++) send_byte(8'($urandom_range(33, 126)));
    wait_idle("tab78_setup");
    er = m_row;
    wq.delete();
    send_byte(8'h09);
    wait_idle("tab78");
    tests++;
    if (wq.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 5'(er + 1)) begin
      failed++;
      $display("FAIL tab_col78: writes=%0d cur=(%0d,%0d), required 0 (%0d,0)", wq.size(), cursor_row, cursor_col, er + 1);
    end
`else
    er = 0;
    tests++;
    if (wq.size() != 1 || wq[0] !== {ea, 8'h09} || cursor_col !== 7'd4 || er != 0) begin
      failed++;
      $display("FAIL tab_printable: n=%0d first=%h col=%0d, required 1 %h09 4",
               wq.size(), wq.size() > 0 ? wq[0] : 20'h0, cursor_col, ea);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0]  seq [10];
    logic [19:0] expq[$];
    int k = 0, n = 0, base_cnt, first_c = 0, last_c = 0, err = 0;
    for (int i = 0; i < 10; i++) seq[i] = 8'($urandom_range(33, 126));
    send_byte(8'h0D);
    wait_idle("b2b_setup");
    wq.delete();
    base_cnt = acc_cnt;
    ch_valid = 1'b1;
    ch_data  = seq[0];
    while (k < 10 && n < 200) begin
      @(negedge clk_pix);
      n++;
      if (acc_cnt - base_cnt > k) begin
        expq.push_back({m_addr(), seq[k]});
        m_byte(seq[k]);
        if (k == 0) first_c = acc_cyc;
        last_c = acc_cyc;
        k++;
        if (k < 10) ch_data = seq[k];
        else ch_valid = 1'b0;
      end
    end
    ch_valid = 1'b0;
    wait_idle("b2b");
    tests++;
    if (k != 10 || last_c - first_c != 18) begin
      failed++;
      $display("FAIL b2b_throughput: accepted=%0d span=%0d cycles, required 10 and 18", k, last_c - first_c);
    end
    for (int i = 0; i < expq.size(); i++)
      if (i >= wq.size() || wq[i] !== expq[i]) err++;
    tests++;
    if (wq.size() != 10 || err != 0) begin
      failed++;
      $display("FAIL b2b_writes: n=%0d bad=%0d, required 10 0", wq.size(), err);
    end
  endtask

  task automatic test_random();
    int err = 0;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) b = 8'h0A;
      else if (r < 12) b = 8'h0D;
      else if (r < 16) b = 8'h08;
      else if (r < 20) b = 8'h09;
      else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h0C);
      end
      send_byte(b);
      wait_idle("rand");
      tests++;
      if (cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col) || scroll_row !== 5'(m_scroll)) begin
        failed++;
        $display("FAIL rand_cursor[%0d] byte %h: cur=(%0d,%0d) scroll=%0d, required (%0d,%0d) %0d",
                 i, b, cursor_row, cursor_col, scroll_row, m_row, m_col, m_scroll);
      end
    end
    for (int i = 0; i < 4096; i++) if (shadow[i] !== exp_mem[i]) err++;
    tests++;
    if (err != 0) begin
      failed++;
      $display("FAIL rand_vram_image: %0d cells differ, required 0", err);
    end
  endtask

  task automatic test_reset_mid_blank();
    int err = 0;
    send_byte(8'h0D);
    while (m_row < ROWS - 1) send_byte(8'h0A);
    wait_idle("rmb_setup");
    send_byte(8'h0A);
    repeat (20) @(negedge clk_pix);
    tests++;
    if (busy !== 1'b1 || vram_we !== 1'b1) begin
      failed++;
      $display("FAIL rmb_in_blank: busy=%0b we=%0b, required 1 1", busy, vram_we);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk_pix);
    wq.delete();
    rst = 1'b0;
    wait_idle("rmb");
    m_clear();
    tests++;
    if (wq.size() != 4096 || wq[0] !== {12'h000, 8'h20}) begin
      failed++;
      $display("FAIL rmb_restart_clear: n=%0d first=%h, required 4096 00020",
               wq.size(), wq.size() > 0 ? wq[0] : 20'h0);
    end
    tests++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || scroll_row !== 5'd0) begin
      failed++;
      $display("FAIL rmb_state: cur=(%0d,%0d) scroll=%0d, required (0,0) 0", cursor_row, cursor_col, scroll_row);
    end
    for (int i = 0; i < 4096; i++) if (shadow[i] !== exp_mem[i]) err++;
    tests++;
    if (err != 0) begin
      failed++;
      $display("FAIL rmb_vram_image: %0d cells differ, required 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_line_wrap();
    test_scroll();
    test_bs_ff();
    test_tab();
    test_back_to_back();
    test_random();
    test_reset_mid_blank();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
